// File: rtl/lotr_pkg.sv
// Shared types and constants for the ring controller tile logic.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD       = 2'b00,
        RD_RSP   = 2'b01,
        WR       = 2'b10,
        WR_BCAST = 2'b11
    } t_opcode;

    localparam int         F2C_ENTRIES = 4;
    localparam int         F2C_IDX_W   = $clog2(F2C_ENTRIES);
    localparam logic [7:0] BCAST_ID    = 8'hFF;

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        PEND_CORE = 2'b01,
        WAIT_RSP  = 2'b10,
        RSP_RDY   = 2'b11
    } t_f2c_state;

    typedef struct packed {
        logic        valid;
        t_f2c_state  state;
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_f2c_entry;

    // An unused entry: FREE, opcode RD, all payload zero.
    function automatic t_f2c_entry f2c_empty();
        t_f2c_entry e;
        e.valid     = 1'b0;
        e.state     = FREE;
        e.requestor = '0;
        e.opcode    = RD;
        e.address   = '0;
        e.data      = '0;
        return e;
    endfunction

endpackage

// File: rtl/rc_f2c_buf.sv
// F2C entry buffer: allocation of incoming requests, in-order dispatch to the
// core, matching of core read data and hand-off of responses to the ring.
// Requests that can go to the core in the same cycle they arrive skip the
// PEND_CORE state; reads that can leave on the ring at once skip RSP_RDY.
module rc_f2c_buf
    import lotr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    // request needing an entry (Q501H)
    input  logic        alloc_vld_i,
    input  logic [9:0]  alloc_requestor_i,
    input  t_opcode     alloc_opcode_i,
    input  logic [31:0] alloc_address_i,
    input  logic [31:0] alloc_data_i,
    output logic        alloc_ok_o,
    // dispatch towards the core
    output logic        disp_vld_o,
    output t_opcode     disp_opcode_o,
    output logic [31:0] disp_address_o,
    output logic [31:0] disp_data_o,
    // core read data (Q501H)
    input  logic        core_rsp_vld_i,
    input  logic [31:0] core_rsp_address_i,
    input  logic [31:0] core_rsp_data_i,
    // ring response slot taken by pass-through traffic
    input  logic        ring_rsp_busy_i,
    output logic        rsp_vld_o,
    output logic [9:0]  rsp_requestor_o,
    output logic [31:0] rsp_address_o,
    output logic [31:0] rsp_data_o
);

    t_f2c_entry entries_q [F2C_ENTRIES];
    t_f2c_entry entries_d [F2C_ENTRIES];
    t_f2c_entry new_entry;

    logic                 free_found, pend_found, match_found, rdy_found;
    logic [F2C_IDX_W-1:0] free_idx, pend_idx, match_idx, rdy_idx;

    // Lowest-index search for each kind of entry; descending loop so the
    // lowest matching index is the last one written.
    always_comb begin
        free_found  = 1'b0;
        pend_found  = 1'b0;
        match_found = 1'b0;
        rdy_found   = 1'b0;
        free_idx    = '0;
        pend_idx    = '0;
        match_idx   = '0;
        rdy_idx     = '0;
        for (int i = F2C_ENTRIES - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = F2C_IDX_W'(i);
            end
            if (entries_q[i].valid && entries_q[i].state == PEND_CORE) begin
                pend_found = 1'b1;
                pend_idx   = F2C_IDX_W'(i);
            end
            if (core_rsp_vld_i && entries_q[i].valid && entries_q[i].state == WAIT_RSP &&
                entries_q[i].address == core_rsp_address_i) begin
                match_found = 1'b1;
                match_idx   = F2C_IDX_W'(i);
            end
            if (entries_q[i].valid && entries_q[i].state == RSP_RDY) begin
                rdy_found = 1'b1;
                rdy_idx   = F2C_IDX_W'(i);
            end
        end
    end

    assign alloc_ok_o = free_found;

    // Entry next-state, dispatch and response selection.
    always_comb begin
        entries_d       = entries_q;
        disp_vld_o      = 1'b0;
        disp_opcode_o   = RD;
        disp_address_o  = '0;
        disp_data_o     = '0;
        rsp_vld_o       = 1'b0;
        rsp_requestor_o = '0;
        rsp_address_o   = '0;
        rsp_data_o      = '0;

        new_entry.valid     = 1'b1;
        new_entry.state     = PEND_CORE;
        new_entry.requestor = alloc_requestor_i;
        new_entry.opcode    = alloc_opcode_i;
        new_entry.address   = alloc_address_i;
        new_entry.data      = alloc_data_i;

        if (pend_found) begin
            // older work waits; the newcomer queues behind it
            disp_vld_o     = 1'b1;
            disp_opcode_o  = entries_q[pend_idx].opcode;
            disp_address_o = entries_q[pend_idx].address;
            disp_data_o    = entries_q[pend_idx].data;
            if (entries_q[pend_idx].opcode == RD) begin
                entries_d[pend_idx].state = WAIT_RSP;
            end else begin
                entries_d[pend_idx] = f2c_empty();
            end
            if (alloc_vld_i && free_found) begin
                entries_d[free_idx] = new_entry;
            end
        end else if (alloc_vld_i && free_found) begin
            // nothing older: goes straight to the core; writes need no entry
            disp_vld_o     = 1'b1;
            disp_opcode_o  = alloc_opcode_i;
            disp_address_o = alloc_address_i;
            disp_data_o    = alloc_data_i;
            if (alloc_opcode_i == RD) begin
                entries_d[free_idx]       = new_entry;
                entries_d[free_idx].state = WAIT_RSP;
            end
        end

        if (match_found) begin
            entries_d[match_idx].data  = core_rsp_data_i;
            entries_d[match_idx].state = RSP_RDY;
        end

        if (!ring_rsp_busy_i) begin
            if (rdy_found) begin
                rsp_vld_o           = 1'b1;
                rsp_requestor_o     = entries_q[rdy_idx].requestor;
                rsp_address_o       = entries_q[rdy_idx].address;
                rsp_data_o          = entries_q[rdy_idx].data;
                entries_d[rdy_idx]  = f2c_empty();
            end else if (match_found) begin
                rsp_vld_o            = 1'b1;
                rsp_requestor_o      = entries_q[match_idx].requestor;
                rsp_address_o        = entries_q[match_idx].address;
                rsp_data_o           = core_rsp_data_i;
                entries_d[match_idx] = f2c_empty();
            end
        end
    end

    // Entry array state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < F2C_ENTRIES; i++) begin
                entries_q[i] <= f2c_empty();
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/ring_controller.sv
// Ring controller for one core tile: Q501H input capture, request
// classification, and registered Q502H ring and core outputs.
// Optional feature macro: RC_BCAST_EN (deliver WR_BCAST to the core as well).
module ring_controller
    import lotr_pkg::*;
(
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [7:0]  CoreID,
    input  logic        RingReqInValidQ500H,
    input  logic [9:0]  RingReqRequestorQ500H,
    input  t_opcode     RingReqInOpcodeQ500H,
    input  logic [31:0] RingReqInAddressQ500H,
    input  logic [31:0] RingReqInDataQ500H,
    input  logic        RingRspInValidQ500H,
    input  logic [9:0]  RingRspRequestorQ500H,
    input  t_opcode     RingRspInOpcodeQ500H,
    input  logic [31:0] RingRspInAddressQ500H,
    input  logic [31:0] RingRspInDataQ500H,
    output logic        RingReqOutValidQ502H,
    output logic [9:0]  RingReqOutRequestorQ502H,
    output t_opcode     RingReqOutOpcodeQ502H,
    output logic [31:0] RingReqOutAddressQ502H,
    output logic [31:0] RingReqOutDataQ502H,
    output logic        RingRspOutValidQ502H,
    output logic [9:0]  RingRspOutRequestorQ502H,
    output t_opcode     RingRspOutOpcodeQ502H,
    output logic [31:0] RingRspOutAddressQ502H,
    output logic [31:0] RingRspOutDataQ502H,
    input  logic        F2C_RspValidQ500H,
    input  t_opcode     F2C_RspOpcodeQ500H,
    input  logic [31:0] F2C_RspAddressQ500H,
    input  logic [31:0] F2C_RspDataQ500H,
    output logic        F2C_ReqValidQ502H,
    output t_opcode     F2C_ReqOpcodeQ502H,
    output logic [31:0] F2C_ReqAddressQ502H,
    output logic [31:0] F2C_ReqDataQ502H
);

    // Q501H captured inputs
    logic        req_vld_q;
    logic [9:0]  req_requestor_q;
    t_opcode     req_opcode_q;
    logic [31:0] req_address_q;
    logic [31:0] req_data_q;
    logic        rsp_vld_q;
    logic [9:0]  rsp_requestor_q;
    t_opcode     rsp_opcode_q;
    logic [31:0] rsp_address_q;
    logic [31:0] rsp_data_q;
    logic        core_vld_q;
    t_opcode     core_opcode_q;
    logic [31:0] core_address_q;
    logic [31:0] core_data_q;

    // Q502H output registers and their next values
    logic        rreq_vld_q, rreq_vld_d;
    logic [9:0]  rreq_requestor_q, rreq_requestor_d;
    t_opcode     rreq_opcode_q, rreq_opcode_d;
    logic [31:0] rreq_address_q, rreq_address_d;
    logic [31:0] rreq_data_q, rreq_data_d;
    logic        rrsp_vld_q, rrsp_vld_d;
    logic [9:0]  rrsp_requestor_q, rrsp_requestor_d;
    t_opcode     rrsp_opcode_q, rrsp_opcode_d;
    logic [31:0] rrsp_address_q, rrsp_address_d;
    logic [31:0] rrsp_data_q, rrsp_data_d;
    logic        f2c_vld_q, f2c_vld_d;
    t_opcode     f2c_opcode_q, f2c_opcode_d;
    logic [31:0] f2c_address_q, f2c_address_d;
    logic [31:0] f2c_data_q, f2c_data_d;

    logic        req_local, req_bcast, req_fwd, alloc_ok;
    logic        disp_vld;
    t_opcode     disp_opcode;
    logic [31:0] disp_address, disp_data;
    logic        buf_rsp_vld;
    logic [9:0]  buf_rsp_requestor;
    logic [31:0] buf_rsp_address, buf_rsp_data;

    // The core's response opcode carries no information the tile needs;
    // responses are identified by address alone.
    logic unused_core_opcode;
    assign unused_core_opcode = ^core_opcode_q;

    // Capture the ring request port every cycle, valid or not.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            req_vld_q       <= 1'b0;
            req_requestor_q <= '0;
            req_opcode_q    <= RD;
            req_address_q   <= '0;
            req_data_q      <= '0;
        end else begin
            req_vld_q       <= RingReqInValidQ500H;
            req_requestor_q <= RingReqRequestorQ500H;
            req_opcode_q    <= RingReqInOpcodeQ500H;
            req_address_q   <= RingReqInAddressQ500H;
            req_data_q      <= RingReqInDataQ500H;
        end
    end

    // Capture the ring response port every cycle, valid or not.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            rsp_vld_q       <= 1'b0;
            rsp_requestor_q <= '0;
            rsp_opcode_q    <= RD;
            rsp_address_q   <= '0;
            rsp_data_q      <= '0;
        end else begin
            rsp_vld_q       <= RingRspInValidQ500H;
            rsp_requestor_q <= RingRspRequestorQ500H;
            rsp_opcode_q    <= RingRspInOpcodeQ500H;
            rsp_address_q   <= RingRspInAddressQ500H;
            rsp_data_q      <= RingRspInDataQ500H;
        end
    end

    // Capture the core response port every cycle, valid or not.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            core_vld_q     <= 1'b0;
            core_opcode_q  <= RD;
            core_address_q <= '0;
            core_data_q    <= '0;
        end else begin
            core_vld_q     <= F2C_RspValidQ500H;
            core_opcode_q  <= F2C_RspOpcodeQ500H;
            core_address_q <= F2C_RspAddressQ500H;
            core_data_q    <= F2C_RspDataQ500H;
        end
    end

    assign req_local = req_vld_q && (req_address_q[31:24] == CoreID) &&
                       (req_opcode_q == RD || req_opcode_q == WR);
`ifdef RC_BCAST_EN
    assign req_bcast = req_vld_q && (req_opcode_q == WR_BCAST) &&
                       (req_address_q[31:24] == BCAST_ID);
`else
    assign req_bcast = 1'b0;
`endif
    // Broadcasts always travel on; local requests only when the buffer is full.
    assign req_fwd = req_vld_q && (!req_local || !alloc_ok);

    rc_f2c_buf u_f2c_buf (
        .clk_i              (QClk),
        .rst_i              (RstQnnnH),
        .alloc_vld_i        (req_local || req_bcast),
        .alloc_requestor_i  (req_requestor_q),
        .alloc_opcode_i     (req_opcode_q),
        .alloc_address_i    (req_address_q),
        .alloc_data_i       (req_data_q),
        .alloc_ok_o         (alloc_ok),
        .disp_vld_o         (disp_vld),
        .disp_opcode_o      (disp_opcode),
        .disp_address_o     (disp_address),
        .disp_data_o        (disp_data),
        .core_rsp_vld_i     (core_vld_q),
        .core_rsp_address_i (core_address_q),
        .core_rsp_data_i    (core_data_q),
        .ring_rsp_busy_i    (rsp_vld_q),
        .rsp_vld_o          (buf_rsp_vld),
        .rsp_requestor_o    (buf_rsp_requestor),
        .rsp_address_o      (buf_rsp_address),
        .rsp_data_o         (buf_rsp_data)
    );

    // Output muxes: ring responses in transit beat locally produced ones.
    always_comb begin
        rreq_vld_d       = req_fwd;
        rreq_requestor_d = req_requestor_q;
        rreq_opcode_d    = req_opcode_q;
        rreq_address_d   = req_address_q;
        rreq_data_d      = req_data_q;

        rrsp_vld_d       = rsp_vld_q;
        rrsp_requestor_d = rsp_requestor_q;
        rrsp_opcode_d    = rsp_opcode_q;
        rrsp_address_d   = rsp_address_q;
        rrsp_data_d      = rsp_data_q;
        if (!rsp_vld_q && buf_rsp_vld) begin
            rrsp_vld_d       = 1'b1;
            rrsp_requestor_d = buf_rsp_requestor;
            rrsp_opcode_d    = RD_RSP;
            rrsp_address_d   = buf_rsp_address;
            rrsp_data_d      = buf_rsp_data;
        end

        f2c_vld_d     = disp_vld;
        f2c_opcode_d  = disp_opcode;
        f2c_address_d = disp_address;
        f2c_data_d    = disp_data;
    end

    // Q502H output registers.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            rreq_vld_q       <= 1'b0;
            rreq_requestor_q <= '0;
            rreq_opcode_q    <= RD;
            rreq_address_q   <= '0;
            rreq_data_q      <= '0;
            rrsp_vld_q       <= 1'b0;
            rrsp_requestor_q <= '0;
            rrsp_opcode_q    <= RD;
            rrsp_address_q   <= '0;
            rrsp_data_q      <= '0;
            f2c_vld_q        <= 1'b0;
            f2c_opcode_q     <= RD;
            f2c_address_q    <= '0;
            f2c_data_q       <= '0;
        end else begin
            rreq_vld_q       <= rreq_vld_d;
            rreq_requestor_q <= rreq_requestor_d;
            rreq_opcode_q    <= rreq_opcode_d;
            rreq_address_q   <= rreq_address_d;
            rreq_data_q      <= rreq_data_d;
            rrsp_vld_q       <= rrsp_vld_d;
            rrsp_requestor_q <= rrsp_requestor_d;
            rrsp_opcode_q    <= rrsp_opcode_d;
            rrsp_address_q   <= rrsp_address_d;
            rrsp_data_q      <= rrsp_data_d;
            f2c_vld_q        <= f2c_vld_d;
            f2c_opcode_q     <= f2c_opcode_d;
            f2c_address_q    <= f2c_address_d;
            f2c_data_q       <= f2c_data_d;
        end
    end

    assign RingReqOutValidQ502H     = rreq_vld_q;
    assign RingReqOutRequestorQ502H = rreq_requestor_q;
    assign RingReqOutOpcodeQ502H    = rreq_opcode_q;
    assign RingReqOutAddressQ502H   = rreq_address_q;
    assign RingReqOutDataQ502H      = rreq_data_q;
    assign RingRspOutValidQ502H     = rrsp_vld_q;
    assign RingRspOutRequestorQ502H = rrsp_requestor_q;
    assign RingRspOutOpcodeQ502H    = rrsp_opcode_q;
    assign RingRspOutAddressQ502H   = rrsp_address_q;
    assign RingRspOutDataQ502H      = rrsp_data_q;
    assign F2C_ReqValidQ502H        = f2c_vld_q;
    assign F2C_ReqOpcodeQ502H       = f2c_opcode_q;
    assign F2C_ReqAddressQ502H      = f2c_address_q;
    assign F2C_ReqDataQ502H         = f2c_data_q;

endmodule

// File: tb/tb_ring_controller.sv
// Scoreboard bench for ring_controller: directed stimulus pushes expected
// outputs (with their arrival cycle) into per-port queues; a monitor pops and
// compares whenever an output valid is seen.
module tb_ring_controller;
    import lotr_pkg::*;

    typedef struct {
        int          cyc;
        logic [9:0]  req;
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        QClk = 1'b0;
    logic        RstQnnnH = 1'b0;
    logic [7:0]  CoreID = 8'h02;
    logic        rq_vld = 1'b0;
    logic [9:0]  rq_req = '0;
    t_opcode     rq_op = RD;
    logic [31:0] rq_addr = '0, rq_data = '0;
    logic        rs_vld = 1'b0;
    logic [9:0]  rs_req = '0;
    t_opcode     rs_op = RD;
    logic [31:0] rs_addr = '0, rs_data = '0;
    logic        cr_vld = 1'b0;
    t_opcode     cr_op = RD_RSP;
    logic [31:0] cr_addr = '0, cr_data = '0;

    logic        ro_vld, so_vld, fq_vld;
    logic [9:0]  ro_req, so_req;
    t_opcode     ro_op, so_op, fq_op;
    logic [31:0] ro_addr, ro_data, so_addr, so_data, fq_addr, fq_data;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   seen = 0;
    exp_t q_ro[$];
    exp_t q_so[$];
    exp_t q_fq[$];
    exp_t e;

    ring_controller dut (
        .QClk                     (QClk),
        .RstQnnnH                 (RstQnnnH),
        .CoreID                   (CoreID),
        .RingReqInValidQ500H      (rq_vld),
        .RingReqRequestorQ500H    (rq_req),
        .RingReqInOpcodeQ500H     (rq_op),
        .RingReqInAddressQ500H    (rq_addr),
        .RingReqInDataQ500H       (rq_data),
        .RingRspInValidQ500H      (rs_vld),
        .RingRspRequestorQ500H    (rs_req),
        .RingRspInOpcodeQ500H     (rs_op),
        .RingRspInAddressQ500H    (rs_addr),
        .RingRspInDataQ500H       (rs_data),
        .RingReqOutValidQ502H     (ro_vld),
        .RingReqOutRequestorQ502H (ro_req),
        .RingReqOutOpcodeQ502H    (ro_op),
        .RingReqOutAddressQ502H   (ro_addr),
        .RingReqOutDataQ502H      (ro_data),
        .RingRspOutValidQ502H     (so_vld),
        .RingRspOutRequestorQ502H (so_req),
        .RingRspOutOpcodeQ502H    (so_op),
        .RingRspOutAddressQ502H   (so_addr),
        .RingRspOutDataQ502H      (so_data),
        .F2C_RspValidQ500H        (cr_vld),
        .F2C_RspOpcodeQ500H       (cr_op),
        .F2C_RspAddressQ500H      (cr_addr),
        .F2C_RspDataQ500H         (cr_data),
        .F2C_ReqValidQ502H        (fq_vld),
        .F2C_ReqOpcodeQ502H       (fq_op),
        .F2C_ReqAddressQ502H      (fq_addr),
        .F2C_ReqDataQ502H         (fq_data)
    );

    always #5 QClk = ~QClk;

    always @(posedge QClk) cyc <= cyc + 1;

    // monitor: one comparison per observed output beat
    always @(posedge QClk) begin
        #1;
        if (!RstQnnnH) begin
            if (ro_vld) begin
                seen++;
                checks++;
                if (q_ro.size() == 0) begin
                    failures++;
                    $display("FAIL ring_req_out unexpected: cyc=%0d req=%0d op=%0d addr=%h data=%h, none required",
                             cyc, ro_req, ro_op, ro_addr, ro_data);
                end else begin
                    e = q_ro.pop_front();
                    if (e.cyc != cyc || e.req !== ro_req || e.op !== ro_op ||
                        e.addr !== ro_addr || e.data !== ro_data) begin
                        failures++;
                        $display("FAIL ring_req_out: got cyc=%0d req=%0d op=%0d addr=%h data=%h, required cyc=%0d req=%0d op=%0d addr=%h data=%h",
                                 cyc, ro_req, ro_op, ro_addr, ro_data, e.cyc, e.req, e.op, e.addr, e.data);
                    end
                end
            end
            if (so_vld) begin
                seen++;
                checks++;
                if (q_so.size() == 0) begin
                    failures++;
                    $display("FAIL ring_rsp_out unexpected: cyc=%0d req=%0d op=%0d addr=%h data=%h, none required",
                             cyc, so_req, so_op, so_addr, so_data);
                end else begin
                    e = q_so.pop_front();
                    if (e.cyc != cyc || e.req !== so_req || e.op !== so_op ||
                        e.addr !== so_addr || e.data !== so_data) begin
                        failures++;
                        $display("FAIL ring_rsp_out: got cyc=%0d req=%0d op=%0d addr=%h data=%h, required cyc=%0d req=%0d op=%0d addr=%h data=%h",
                                 cyc, so_req, so_op, so_addr, so_data, e.cyc, e.req, e.op, e.addr, e.data);
                    end
                end
            end
            if (fq_vld) begin
                seen++;
                checks++;
                if (q_fq.size() == 0) begin
                    failures++;
                    $display("FAIL f2c_req unexpected: cyc=%0d op=%0d addr=%h data=%h, none required",
                             cyc, fq_op, fq_addr, fq_data);
                end else begin
                    e = q_fq.pop_front();
                    if (e.cyc != cyc || e.op !== fq_op || e.addr !== fq_addr || e.data !== fq_data) begin
                        failures++;
                        $display("FAIL f2c_req: got cyc=%0d op=%0d addr=%h data=%h, required cyc=%0d op=%0d addr=%h data=%h",
                                 cyc, fq_op, fq_addr, fq_data, e.cyc, e.op, e.addr, e.data);
                    end
                end
            end
        end
    end

    function automatic void exp_ro(input int dc, input logic [9:0] r, input t_opcode op,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t ev;
        ev.cyc = cyc + dc; ev.req = r; ev.op = op; ev.addr = a; ev.data = d;
        q_ro.push_back(ev);
        pushed++;
    endfunction

    function automatic void exp_so(input int dc, input logic [9:0] r,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t ev;
        ev.cyc = cyc + dc; ev.req = r; ev.op = RD_RSP; ev.addr = a; ev.data = d;
        q_so.push_back(ev);
        pushed++;
    endfunction

    function automatic void exp_fq(input int dc, input t_opcode op,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t ev;
        ev.cyc = cyc + dc; ev.req = '0; ev.op = op; ev.addr = a; ev.data = d;
        q_fq.push_back(ev);
        pushed++;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic ring_req(input logic [9:0] r, input t_opcode op,
                            input logic [31:0] a, input logic [31:0] d);
        rq_vld = 1'b1; rq_req = r; rq_op = op; rq_addr = a; rq_data = d;
    endtask

    task automatic ring_rsp(input logic [9:0] r, input t_opcode op,
                            input logic [31:0] a, input logic [31:0] d);
        rs_vld = 1'b1; rs_req = r; rs_op = op; rs_addr = a; rs_data = d;
    endtask

    task automatic core_rsp(input logic [31:0] a, input logic [31:0] d);
        cr_vld = 1'b1; cr_op = RD_RSP; cr_addr = a; cr_data = d;
    endtask

    // advance to the next falling edge and drop all valids (payload is held)
    task automatic step();
        @(negedge QClk);
        rq_vld = 1'b0;
        rs_vld = 1'b0;
        cr_vld = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ro_vld"}, 32'(ro_vld), 32'd0);
        chk({tag, "_ro_req"}, 32'(ro_req), 32'd0);
        chk({tag, "_ro_op"}, 32'(ro_op), 32'(RD));
        chk({tag, "_ro_addr"}, ro_addr, 32'd0);
        chk({tag, "_ro_data"}, ro_data, 32'd0);
        chk({tag, "_so_vld"}, 32'(so_vld), 32'd0);
        chk({tag, "_so_op"}, 32'(so_op), 32'(RD));
        chk({tag, "_so_addr"}, so_addr, 32'd0);
        chk({tag, "_so_data"}, so_data, 32'd0);
        chk({tag, "_fq_vld"}, 32'(fq_vld), 32'd0);
        chk({tag, "_fq_op"}, 32'(fq_op), 32'(RD));
        chk({tag, "_fq_addr"}, fq_addr, 32'd0);
    endtask

    initial begin
        #1 RstQnnnH = 1'b1;
        repeat (3) @(negedge QClk);
        chk_reset_outputs("reset");
        RstQnnnH = 1'b0;
        step(); step();

        // local write: delivered to core, not forwarded
        ring_req(10'd1, WR, 32'h0200_1111, 32'h1111_1111);
        exp_fq(2, WR, 32'h0200_1111, 32'h1111_1111);
        step();

        // foreign write passes through unchanged
        ring_req(10'd5, WR, 32'hAA00_0000, 32'h1234_5678);
        exp_ro(2, 10'd5, WR, 32'hAA00_0000, 32'h1234_5678);
        step();

        // same payload without valid: nothing anywhere
        rq_req = 10'd5; rq_op = WR; rq_addr = 32'hAA00_0000; rq_data = 32'h1234_5678;
        step(); step(); step();

        // broadcast write
        ring_req(10'd4, WR_BCAST, 32'hFF00_0000, 32'h6666_6666);
        exp_ro(2, 10'd4, WR_BCAST, 32'hFF00_0000, 32'h6666_6666);
`ifdef RC_BCAST_EN
        exp_fq(2, WR_BCAST, 32'hFF00_0000, 32'h6666_6666);
`endif
        step();

        // tile address but not RD/WR: treated as foreign
        ring_req(10'd2, RD_RSP, 32'h0200_0000, 32'h0000_0077);
        exp_ro(2, 10'd2, RD_RSP, 32'h0200_0000, 32'h0000_0077);
        step();

        // read round trip
        ring_req(10'd3, RD, 32'h0200_0000, 32'h0000_0000);
        exp_fq(2, RD, 32'h0200_0000, 32'h0000_0000);
        step(); step();
        core_rsp(32'h0200_0000, 32'h6666_6666);
        exp_so(2, 10'd3, 32'h0200_0000, 32'h6666_6666);
        step(); step(); step();

        // core data collides with a passing ring response
        ring_req(10'd7, RD, 32'h0200_0040, 32'h0000_0040);
        exp_fq(2, RD, 32'h0200_0040, 32'h0000_0040);
        step(); step();
        core_rsp(32'h0200_0040, 32'hABCD_0001);
        ring_rsp(10'd9, RD_RSP, 32'h0500_0000, 32'h5555_AAAA);
        rrsp_push_pair();
        step(); step(); step(); step();

        // five reads with no responses: the fifth recirculates
        for (int i = 0; i < 5; i++) begin
            ring_req(10'(16 + i), RD, 32'h0200_0100 + 32'(4 * i), 32'(i));
            if (i < 4) exp_fq(2, RD, 32'h0200_0100 + 32'(4 * i), 32'(i));
            else       exp_ro(2, 10'(16 + i), RD, 32'h0200_0100 + 32'(4 * i), 32'(i));
            step();
        end
        step(); step();

        // a response for no waiting entry is dropped
        core_rsp(32'h0200_0999, 32'hDEAD_BEEF);
        step();

        // freeing entry 0, then reusing it on the very next cycle
        core_rsp(32'h0200_0100, 32'hC0DE_0000);
        exp_so(2, 10'd16, 32'h0200_0100, 32'hC0DE_0000);
        step();
        ring_req(10'd20, RD, 32'h0200_0200, 32'h0000_0200);
        exp_fq(2, RD, 32'h0200_0200, 32'h0000_0200);
        step();
        for (int i = 1; i < 4; i++) begin
            core_rsp(32'h0200_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            exp_so(2, 10'(16 + i), 32'h0200_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            step();
        end
        core_rsp(32'h0200_0200, 32'hC0DE_0200);
        exp_so(2, 10'd20, 32'h0200_0200, 32'hC0DE_0200);
        step(); step(); step(); step();

        // reset in the middle of traffic discards entries and in-flight data
        ring_req(10'd11, RD, 32'h0200_0300, 32'h0000_0300);
        exp_fq(2, RD, 32'h0200_0300, 32'h0000_0300);
        step(); step(); step();
        ring_req(10'd12, WR, 32'h0300_0000, 32'h3333_3333);
        step();
        #2 RstQnnnH = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge QClk);
        @(negedge QClk);
        RstQnnnH = 1'b0;
        step();
        core_rsp(32'h0200_0300, 32'h9999_9999);
        step(); step(); step();

        // normal operation resumes after reset
        ring_req(10'd13, WR, 32'h0200_0400, 32'h4444_4444);
        exp_fq(2, WR, 32'h0200_0400, 32'h4444_4444);
        step();
        repeat (6) step();

        chk("ring_req_out_leftover", 32'(q_ro.size()), 32'd0);
        chk("ring_rsp_out_leftover", 32'(q_so.size()), 32'd0);
        chk("f2c_req_leftover", 32'(q_fq.size()), 32'd0);
        chk("output_beats_total", 32'(seen), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ring response first, then the held core data one cycle later
    task automatic rrsp_push_pair();
        exp_so(2, 10'd9, 32'h0500_0000, 32'h5555_AAAA);
        q_so[q_so.size() - 1].op = RD_RSP;
        exp_so(3, 10'd7, 32'h0200_0040, 32'hABCD_0001);
    endtask

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
